// File: rtl/led_seq_pkg.sv
// Shared constants for the LED pattern sequencer: pattern mode encodings
// and bounce direction values.
package led_seq_pkg;

    localparam logic [1:0] MODE_CHASE  = 2'b00;
    localparam logic [1:0] MODE_BOUNCE = 2'b01;
    localparam logic [1:0] MODE_BINARY = 2'b10;
    localparam logic [1:0] MODE_BLINK  = 2'b11;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/led_pattern_seq_tick_prescaler.sv
// Programmable prescaler: produces one advance request every div_q+1 cycles
// while free-running, or one per step pulse while paused.
module tick_prescaler
    import led_seq_pkg::*;
#(
    parameter int DIV_WIDTH = 25
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 step,
    input  logic                 clr,
    input  logic [DIV_WIDTH-1:0] div_q,
    output logic                 adv
);

    logic [DIV_WIDTH-1:0] cnt;
    logic                 term;

    // Terminal detect uses >= so a lowered div_q fires next cycle instead of
    // waiting for the counter to wrap; clr suppresses any advance that cycle.
    always_comb begin
        term = (cnt >= div_q);
        adv  = 1'b0;
        if (!clr) begin
            adv = en ? term : step;
        end
    end

    // Cycle counter: runs while enabled, holds while paused, restarts on an
    // advance or when the pattern is restarted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= term ? '0 : cnt + DIV_WIDTH'(1);
        end else if (step) begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/led_pattern_seq.sv
// N-LED pattern sequencer with four runtime-selectable patterns, run/pause,
// single-step and a loadable prescaler. tick/wrap are exported so other
// blocks can synchronise to pattern advances and pattern restarts.
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int N_LEDS    = 4,
    parameter int DIV_WIDTH = 25,
    parameter int DIV_RESET = 250000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 step,
    input  logic [1:0]           mode,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div,
    output logic [N_LEDS-1:0]    leds,
    output logic                 tick,
    output logic                 wrap
);

    localparam logic [N_LEDS-1:0] ONE  = N_LEDS'(1);
    localparam logic [N_LEDS-1:0] LAST = N_LEDS'(N_LEDS - 1);
    localparam logic [N_LEDS-1:0] ALL  = '1;

    logic [1:0]           mode_q;
    logic                 start_q;   // set by reset: first edge loads the start pattern
    logic [DIV_WIDTH-1:0] div_q;
    logic [N_LEDS-1:0]    pos;
    logic                 dir;
    logic                 chg;
    logic                 adv;
    logic [N_LEDS-1:0]    pos_n;
    logic                 dir_n;
    logic [N_LEDS-1:0]    leds_n;
    logic                 wrap_n;

    function automatic logic [N_LEDS-1:0] start_pat(input logic [1:0] m);
        case (m)
            MODE_BINARY: start_pat = '0;
            MODE_BLINK:  start_pat = ALL;
            default:     start_pat = ONE;
        endcase
    endfunction

    // A restart (out of reset or on a mode change) reloads the start pattern
    // and overrides any advance in the same cycle.
    assign chg = start_q || (mode != mode_q);

    tick_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .step  (step),
        .clr   (chg),
        .div_q (div_q),
        .adv   (adv)
    );

    // Next pattern state for one advance in the current mode.
    always_comb begin
        pos_n  = pos;
        dir_n  = dir;
        leds_n = leds;
        wrap_n = 1'b0;
        case (mode_q)
            MODE_CHASE: begin
                wrap_n = (pos == LAST);
                pos_n  = wrap_n ? '0 : pos + ONE;
                leds_n = ONE << pos_n;
            end
            MODE_BOUNCE: begin
                if (N_LEDS == 1) begin
                    pos_n = '0;
                end else begin
                    // Direction is set on arrival at an end so endpoints are
                    // shown once per sweep.
                    pos_n = (dir == DIR_UP) ? pos + ONE : pos - ONE;
                    if (pos_n == LAST) begin
                        dir_n = DIR_DN;
                    end else if (pos_n == '0) begin
                        dir_n = DIR_UP;
                    end
                end
                wrap_n = (pos_n == '0);
                leds_n = ONE << pos_n;
            end
            MODE_BINARY: begin
                wrap_n = (pos == ALL);
                pos_n  = pos + ONE;
                leds_n = pos_n;
            end
            default: begin
                wrap_n = (leds == ALL);
                leds_n = ~leds;
            end
        endcase
    end

    // Control registers: restart flag, sampled mode and prescaler shadow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q <= 1'b1;
            mode_q  <= MODE_CHASE;
            div_q   <= DIV_WIDTH'(DIV_RESET);
        end else begin
            start_q <= 1'b0;
            mode_q  <= mode;
            if (div_load) begin
                div_q <= div;
            end
        end
    end

    // Pattern state and LED/pulse outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos  <= '0;
            dir  <= DIR_UP;
            leds <= '0;
            tick <= 1'b0;
            wrap <= 1'b0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            if (chg) begin
                pos  <= '0;
                dir  <= DIR_UP;
                leds <= start_pat(mode);
            end else if (adv) begin
                pos  <= pos_n;
                dir  <= dir_n;
                leds <= leds_n;
                tick <= 1'b1;
                wrap <= wrap_n;
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Scoreboard bench for led_pattern_seq (N_LEDS=4, short reset divider).
module tb_led_pattern_seq;
    import led_seq_pkg::*;

    localparam int DW   = 25;
    localparam int DRST = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          step;
    logic [1:0]    mode;
    logic          div_load;
    logic [DW-1:0] div;
    logic [3:0]    leds;
    logic          tick;
    logic          wrap;

    led_pattern_seq #(
        .N_LEDS    (4),
        .DIV_WIDTH (DW),
        .DIV_RESET (DRST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .step     (step),
        .mode     (mode),
        .div_load (div_load),
        .div      (div),
        .leds     (leds),
        .tick     (tick),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] leds;
        logic       tick;
        logic       wrap;
    } exp_t;

    exp_t sbq[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: pattern phase within its period.
    logic       m_start;
    logic [1:0] m_mode;
    int         m_cnt;
    int         m_div;
    int         m_phase;
    logic [3:0] m_leds;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int period(input logic [1:0] m);
        case (m)
            MODE_CHASE:  return 4;
            MODE_BOUNCE: return 6;
            MODE_BINARY: return 16;
            default:     return 2;
        endcase
    endfunction

    function automatic logic [3:0] pat(input logic [1:0] m, input int ph);
        int bseq[6] = '{0, 1, 2, 3, 2, 1};
        logic [31:0] p;
        p = ph;
        case (m)
            MODE_CHASE:  return 4'b0001 << ph;
            MODE_BOUNCE: return 4'b0001 << bseq[ph];
            MODE_BINARY: return p[3:0];
            default:     return (ph == 0) ? 4'b1111 : 4'b0000;
        endcase
    endfunction

    task automatic model_reset();
        m_start = 1'b1;
        m_mode  = MODE_CHASE;
        m_cnt   = 0;
        m_div   = DRST;
        m_phase = 0;
        m_leds  = 4'b0000;
    endtask

    // Predict the next edge from current inputs, push, then compare.
    task automatic cycle();
        exp_t e;
        logic c, a;
        c = m_start || (mode != m_mode);
        a = !c && (en ? (m_cnt >= m_div) : step);
        e.leds = m_leds;
        e.tick = 1'b0;
        e.wrap = 1'b0;
        if (c) begin
            m_phase = 0;
            e.leds  = pat(mode, 0);
        end else if (a) begin
            m_phase = (m_phase + 1) % period(m_mode);
            e.leds  = pat(m_mode, m_phase);
            e.tick  = 1'b1;
            e.wrap  = (m_mode == MODE_BLINK) ? (m_phase == 1) : (m_phase == 0);
        end
        if (c) m_cnt = 0;
        else if (en) m_cnt = (m_cnt >= m_div) ? 0 : m_cnt + 1;
        else if (step) m_cnt = 0;
        if (div_load) m_div = int'(div);
        m_mode  = mode;
        m_start = 1'b0;
        m_leds  = e.leds;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("leds", 32'(leds), 32'(e.leds));
        chk("tick", 32'(tick), 32'(e.tick));
        chk("wrap", 32'(wrap), 32'(e.wrap));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        bit found;
        rst = 1'b1; en = 1'b1; step = 1'b0; mode = MODE_CHASE;
        div_load = 1'b0; div = DW'(3);
        #2 rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_wrap", 32'(wrap), 32'h0);

        // CHASE, div=3, loaded on the first edge after release
        rst = 1'b1; div_load = 1'b1;
        cycle();
        div_load = 1'b0;
        run(20);

        // BOUNCE at full speed
        mode = MODE_BOUNCE; div = DW'(0); div_load = 1'b1;
        cycle();
        div_load = 1'b0;
        run(14);

        // BINARY paused: single steps, then frozen
        mode = MODE_BINARY; en = 1'b0;
        run(3);
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; cycle(); step = 1'b0; run(2);
        end
        run(5);

        // Lower the divider while the count is already past the new value
        en = 1'b1; div = DW'(10); div_load = 1'b1;
        cycle();
        div_load = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (m_cnt == 7) found = 1'b1; else cycle();
        end
        if (!found) begin n_err++; $display("FAIL seek_cnt7: not reached"); end
        div = DW'(2); div_load = 1'b1;
        cycle();
        div_load = 1'b0;
        run(10);

        // Mode change coincident with a pending CHASE advance at 0100
        mode = MODE_CHASE; div = DW'(3); div_load = 1'b1;
        cycle();
        div_load = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (m_leds == 4'b0100 && m_cnt == m_div) found = 1'b1; else cycle();
        end
        if (!found) begin n_err++; $display("FAIL seek_pending: not reached"); end
        mode = MODE_BLINK;
        run(12);

        // Asynchronous reset between clock edges
        #2 rst = 1'b0;
        #1;
        chk("arst_leds", 32'(leds), 32'h0);
        chk("arst_tick", 32'(tick), 32'h0);
        chk("arst_wrap", 32'(wrap), 32'h0);
        model_reset();
        mode = MODE_CHASE; en = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_hold", 32'(leds), 32'h0);
        rst = 1'b1;
        run(16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
